// File: rtl/usb_cmd_parser_if.sv
// FIFO read port and buffer-memory write port of the USB command parser.
// The master modport is the parser; the slave modport is the FIFO/memory side.
interface usb_cmd_parser_if;
  logic [31:0] usb_rd_data;
  logic        usb_rd_valid;
  logic        usb_rd_ready;
  logic        usb_rd;
  logic        mem_wr;
  logic        mem_wr_ready;
  logic [25:0] mem_addr;
  logic [31:0] mem_wr_data;

  modport master (
    input  usb_rd_data, usb_rd_valid, usb_rd_ready, mem_wr_ready,
    output usb_rd, mem_wr, mem_addr, mem_wr_data
  );

  modport slave (
    output usb_rd_data, usb_rd_valid, usb_rd_ready, mem_wr_ready,
    input  usb_rd, mem_wr, mem_addr, mem_wr_data
  );
endinterface

// File: rtl/usb_cmd_parser.sv
// Parses header-framed packets from the USB FIFO into buffer writes or key/status updates.
// Define USB_CMD_PARSER_ERR_CNT_EN to build the saturating err_cnt error counter.
module usb_cmd_parser (
  input  logic                    clk,
  input  logic                    rst,
  usb_cmd_parser_if.master        bus,
  output logic [2:0]              trans_type,
  output logic [31:0]             key_status,
  output logic                    key_status_valid,
  output logic                    busy,
  output logic                    err,
  output logic [7:0]              err_cnt
);

  typedef enum logic [1:0] {HDR, WRITE, KEY, DRAIN} state_t;

  typedef enum logic [2:0] {
    T_NONE      = 3'd0,
    T_CODE      = 3'd1,
    T_V_BUFFER  = 3'd2,
    T_KEY       = 3'd3,
    T_SR_BUFFER = 3'd5,
    T_SL_BUFFER = 3'd6
  } pkt_t;

  state_t      state;
  logic [12:0] cnt;
  logic [23:0] idx;

  logic        pop;
  logic [2:0]  hdr_type;
  logic [12:0] hdr_n;
  logic        hdr_ok;
  logic        type_known;
  logic        hdr_err;

  always_comb begin
    pop        = bus.usb_rd & bus.usb_rd_ready & bus.usb_rd_valid;
    hdr_type   = bus.usb_rd_data[31:29];
    hdr_n      = bus.usb_rd_data[28:16];
    hdr_ok     = (bus.usb_rd_data[15:0] == 16'hA55A) && (hdr_n != '0);
    type_known = 1'b0;
    case (hdr_type)
      T_NONE, T_CODE, T_V_BUFFER, T_KEY, T_SR_BUFFER, T_SL_BUFFER: type_known = 1'b1;
      default: type_known = 1'b0;
    endcase
    // Bad magic and N=0 are one event; unknown type only counts on an otherwise good header.
    hdr_err    = pop && (state == HDR) && (!hdr_ok || !type_known);
  end

  assign busy = (state != HDR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= HDR;
      cnt              <= '0;
      idx              <= '0;
      bus.usb_rd       <= 1'b0;
      bus.mem_wr       <= 1'b0;
      bus.mem_addr     <= '0;
      bus.mem_wr_data  <= '0;
      trans_type       <= '0;
      key_status       <= '0;
      key_status_valid <= 1'b0;
      err              <= 1'b0;
    end else begin
      key_status_valid <= 1'b0;
      if (hdr_err)
        err <= 1'b1;
      case (state)
        HDR: begin
          bus.usb_rd <= 1'b1;
          if (pop && hdr_ok) begin
            trans_type <= hdr_type;
            cnt        <= hdr_n;
            idx        <= '0;
            case (hdr_type)
              T_CODE, T_V_BUFFER, T_SR_BUFFER, T_SL_BUFFER: state <= WRITE;
              T_KEY:   state <= KEY;
              default: state <= DRAIN;
            endcase
          end
        end
        WRITE: begin
          // Only one word in flight: reads stop until the memory takes the pending write.
          if (bus.mem_wr) begin
            if (bus.mem_wr_ready) begin
              bus.mem_wr <= 1'b0;
              bus.usb_rd <= 1'b1;
              if (cnt == '0)
                state <= HDR;
            end
          end else if (pop) begin
            bus.mem_wr_data <= bus.usb_rd_data;
            bus.mem_addr    <= {idx, 2'b00};
            bus.mem_wr      <= 1'b1;
            bus.usb_rd      <= 1'b0;
            idx             <= idx + 24'd1;
            cnt             <= cnt - 13'd1;
          end
        end
        KEY: begin
          if (pop) begin
            if (idx == '0) begin
              key_status       <= bus.usb_rd_data;
              key_status_valid <= 1'b1;
            end
            idx <= idx + 24'd1;
            cnt <= cnt - 13'd1;
            if (cnt == 13'd1)
              state <= HDR;
          end
        end
        DRAIN: begin
          if (pop) begin
            idx <= idx + 24'd1;
            cnt <= cnt - 13'd1;
            if (cnt == 13'd1)
              state <= HDR;
          end
        end
      endcase
    end
  end

`ifdef USB_CMD_PARSER_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      err_cnt <= '0;
    else if (hdr_err && (err_cnt != 8'hFF))
      err_cnt <= err_cnt + 8'd1;
  end
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_usb_cmd_parser.sv
// Scoreboard bench for usb_cmd_parser: directed packets, queued expectations, decoupled monitor.
module tb_usb_cmd_parser;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  trans_type;
  logic [31:0] key_status;
  logic        key_status_valid;
  logic        busy;
  logic        err;
  logic [7:0]  err_cnt;

  usb_cmd_parser_if bus ();

  usb_cmd_parser dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus),
    .trans_type       (trans_type),
    .key_status       (key_status),
    .key_status_valid (key_status_valid),
    .busy             (busy),
    .err              (err),
    .err_cnt          (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [25:0] addr;
    logic [31:0] data;
  } wr_t;

  logic [31:0] fifo[$];
  wr_t         wq[$];
  logic [31:0] kq[$];

  int n_checks = 0;
  int n_fail   = 0;
  logic rdy_en = 1'b1;
  logic pop_pend = 1'b0;

`ifdef USB_CMD_PARSER_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  function automatic logic [31:0] exp_cnt(input int k);
    return CNT_EN ? 32'(k) : 32'd0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic flag_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got event expected none", name);
  endtask

  // FIFO and memory-ready model; all inputs change on the falling edge.
  initial begin
    bus.usb_rd_data  = '0;
    bus.usb_rd_valid = 1'b0;
    bus.usb_rd_ready = 1'b1;
    bus.mem_wr_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (pop_pend && fifo.size() != 0)
        void'(fifo.pop_front());
      bus.usb_rd_valid = (fifo.size() != 0);
      bus.usb_rd_data  = (fifo.size() != 0) ? fifo[0] : 32'd0;
      bus.mem_wr_ready = rdy_en;
      pop_pend = bus.usb_rd && bus.usb_rd_ready && bus.usb_rd_valid && !rst;
    end
  end

  // Monitor: compares every presented write and key pulse against the queues.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        if (bus.mem_wr) begin
          check("usb_rd_low_while_write", 32'(bus.usb_rd), 32'd0);
          if (wq.size() == 0)
            flag_fail("unexpected_mem_wr");
          else begin
            check("mem_addr", 32'(bus.mem_addr), 32'(wq[0].addr));
            check("mem_wr_data", bus.mem_wr_data, wq[0].data);
            if (bus.mem_wr_ready)
              void'(wq.pop_front());
          end
        end
        if (key_status_valid) begin
          if (kq.size() == 0)
            flag_fail("unexpected_key_status_valid");
          else begin
            check("key_status", key_status, kq[0]);
            void'(kq.pop_front());
          end
        end
      end
    end
  end

  task automatic wait_idle();
    int unsigned t;
    bit done;
    done = 1'b0;
    for (t = 0; t < 300 && !done; t++) begin
      @(negedge clk);
      #2;
      done = (fifo.size() == 0) && !pop_pend && !busy && !bus.mem_wr;
    end
    if (!done) flag_fail("wait_idle_timeout");
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_mem_wr();
    int unsigned t;
    bit done;
    done = 1'b0;
    for (t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      #2;
      done = bus.mem_wr;
    end
    if (!done) flag_fail("wait_mem_wr_timeout");
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_usb_rd"}, 32'(bus.usb_rd), 32'd0);
    check({tag, "_mem_wr"}, 32'(bus.mem_wr), 32'd0);
    check({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
    check({tag, "_mem_wr_data"}, bus.mem_wr_data, 32'd0);
    check({tag, "_trans_type"}, 32'(trans_type), 32'd0);
    check({tag, "_key_status"}, key_status, 32'd0);
    check({tag, "_key_status_valid"}, 32'(key_status_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned sz;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    check_zero_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // KEY_AND_STATUS, one payload word
    kq.push_back(32'h9FFF0000);
    fifo.push_back(32'h6001A55A);
    fifo.push_back(32'h9FFF0000);
    wait_idle();
    check("key_busy_idle", 32'(busy), 32'd0);
    check("key_status_hold", key_status, 32'h9FFF0000);
    check("key_trans_type", 32'(trans_type), 32'd3);
    check("key_err", 32'(err), 32'd0);

    // CODE, two words
    wq.push_back('{addr: 26'd0, data: 32'h0123ABCD});
    wq.push_back('{addr: 26'd4, data: 32'h89ABCDEF});
    fifo.push_back(32'h2002A55A);
    fifo.push_back(32'h0123ABCD);
    fifo.push_back(32'h89ABCDEF);
    wait_idle();
    check("code_trans_type", 32'(trans_type), 32'd1);
    check("code_wq_empty", 32'(wq.size()), 32'd0);

    // CODE with memory stalled for 5 cycles on the first write
    rdy_en = 1'b0;
    wq.push_back('{addr: 26'd0, data: 32'hA1A1A1A1});
    wq.push_back('{addr: 26'd4, data: 32'hB2B2B2B2});
    fifo.push_back(32'h2002A55A);
    fifo.push_back(32'hA1A1A1A1);
    fifo.push_back(32'hB2B2B2B2);
    wait_mem_wr();
    sz = fifo.size();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #2;
      check("stall_mem_wr", 32'(bus.mem_wr), 32'd1);
      check("stall_usb_rd", 32'(bus.usb_rd), 32'd0);
      check("stall_no_pop", 32'(fifo.size()), 32'(sz));
    end
    rdy_en = 1'b1;
    wait_idle();
    check("stall_wq_empty", 32'(wq.size()), 32'd0);

    // NONE, three words drained
    fifo.push_back(32'h0003A55A);
    fifo.push_back(32'h11111111);
    fifo.push_back(32'h22222222);
    fifo.push_back(32'h33333333);
    wait_idle();
    check("none_trans_type", 32'(trans_type), 32'd0);
    check("none_err", 32'(err), 32'd0);

    // bad magic, then a normal KEY packet
    fifo.push_back(32'h20020000);
    wait_idle();
    check("badmagic_err", 32'(err), 32'd1);
    check("badmagic_err_cnt", 32'(err_cnt), exp_cnt(1));
    check("badmagic_busy", 32'(busy), 32'd0);
    kq.push_back(32'h55AA1234);
    fifo.push_back(32'h6001A55A);
    fifo.push_back(32'h55AA1234);
    wait_idle();
    check("after_err_key", key_status, 32'h55AA1234);

    // N=0 header, then unknown type 4 with one word
    fifo.push_back(32'h2000A55A);
    wait_idle();
    check("nzero_err_cnt", 32'(err_cnt), exp_cnt(2));
    fifo.push_back(32'h8001A55A);
    fifo.push_back(32'hDEADBEEF);
    wait_idle();
    check("unknown_err", 32'(err), 32'd1);
    check("unknown_err_cnt", 32'(err_cnt), exp_cnt(3));
    check("unknown_trans_type", 32'(trans_type), 32'd4);

    // SL_BUFFER aborted by reset with a write pending
    rdy_en = 1'b0;
    wq.push_back('{addr: 26'd0, data: 32'h11112222});
    fifo.push_back(32'hC004A55A);
    fifo.push_back(32'h11112222);
    wait_mem_wr();
    check("sl_trans_type", 32'(trans_type), 32'd6);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    wq.delete();
    #2;
    check_zero_outputs("midreset");
    @(negedge clk);
    rdy_en = 1'b1;
    rst = 1'b0;
    kq.push_back(32'h0BADF00D);
    fifo.push_back(32'h6001A55A);
    fifo.push_back(32'h0BADF00D);
    wait_idle();
    check("post_reset_key", key_status, 32'h0BADF00D);
    check("post_reset_err", 32'(err), 32'd0);

    check("final_wq_empty", 32'(wq.size()), 32'd0);
    check("final_kq_empty", 32'(kq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/usb_cmd_parser.md
USB_CMD_PARSER -- requirements
Module: usb_cmd_parser

Interface
REQ-001 SHALL have clk, input, 1: clock; all logic is on posedge clk.
REQ-002 SHALL have rst, input, 1: reset, synchronous, active-high.
REQ-003 SHALL have usb_rd_data, input, 32: FIFO head word.
REQ-004 SHALL have usb_rd_valid, input, 1: head word present.
REQ-005 SHALL have usb_rd_ready, input, 1: FIFO accepts pop.
REQ-006 SHALL have usb_rd, output, 1: pop request; a word is consumed only in a cycle where usb_rd & usb_rd_ready & usb_rd_valid (a "pop").
REQ-007 SHALL have trans_type, output, 3: type of the current packet, for the buffer address translator.
REQ-008 SHALL have mem_wr, output, 1, and mem_wr_ready, input, 1: write strobe and memory-accept signal.
REQ-009 SHALL have mem_addr, output, 26: byte offset within the packet's buffer.
REQ-010 SHALL have mem_wr_data, output, 32: write data.
REQ-011 SHALL have key_status, output, 32, and key_status_valid, output, 1 (one-cycle pulse).
REQ-012 SHALL have busy, output, 1: high whenever the state is not HDR.
REQ-013 SHALL have err, output, 1: sticky error flag.
REQ-014 SHALL have err_cnt, output, 8: error count.

Function
REQ-015 SHALL define header word fields: [31:29] type, [28:16] payload word count N, [15:0] magic, where magic must equal 16'hA55A.
REQ-016 SHALL recognise these types: NONE=0, CODE=1, V_BUFFER=2, KEY_AND_STATUS=3, SR_BUFFER=5, SL_BUFFER=6; types 4 and 7 are unknown.
REQ-017 SHALL implement states HDR, WRITE, KEY, DRAIN.
REQ-018 SHALL, in HDR, assert usb_rd and decode every popped word as a header.
REQ-019 SHALL, in HDR, discard a popped word with a bad magic, or with N=0, set err, and remain in HDR.
REQ-020 SHALL, on a valid header, latch trans_type, load a remaining-word counter with N, and clear the word index.
REQ-021 SHALL route a valid header by type:
- CODE, V_BUFFER, SL_BUFFER, SR_BUFFER -> WRITE;
- KEY_AND_STATUS -> KEY;
- NONE -> DRAIN;
- unknown types -> DRAIN with err set.
REQ-022 SHALL, in WRITE, register each popped word into mem_wr_data with mem_addr = index*4, and assert mem_wr on the next cycle.
REQ-023 SHALL hold mem_wr, mem_addr and mem_wr_data stable until a cycle with mem_wr_ready high, then drop mem_wr on the following cycle.
REQ-024 SHALL deassert usb_rd while a write is pending, so at most one word is in flight.
REQ-025 SHALL, in KEY, latch the first popped payload word into key_status and pulse key_status_valid for exactly 1 cycle, one cycle after that pop; any remaining words are popped and discarded.
REQ-026 SHALL, in DRAIN, pop and discard words with no memory write.
REQ-027 SHALL decrement the counter on every payload pop, and return to HDR after the pop that takes the counter from 1 to 0 (in WRITE: after that word's write is accepted).
REQ-028 SHALL accept the next header on the cycle after the state returns to HDR.
REQ-029 SHALL have a throughput of 1 word per 2 cycles in WRITE when mem_wr_ready is held high, and 1 word per cycle in KEY and DRAIN.
REQ-030 SHALL, when usb_rd_valid is low, not advance state, counter or index.
REQ-031 SHALL compute mem_addr from an index that is 24 bits wide (index*4 fits in 26 bits); N ≤ 8191, so the index never wraps.

Reset
REQ-032 SHALL, while rst is high, force state HDR and clear usb_rd, mem_wr, mem_addr, mem_wr_data, trans_type, key_status, key_status_valid, err and err_cnt to 0.
REQ-033 SHALL treat rst asserted mid-packet as aborting the packet: the pending write is dropped, and the first word popped after reset is decoded as a header.

Configuration
REQ-034 SHALL, when macro USB_CMD_PARSER_ERR_CNT_EN is defined, increment err_cnt by 1 on each error event (bad magic, N=0, unknown type), saturating at 8'hFF.
REQ-035 SHALL, when USB_CMD_PARSER_ERR_CNT_EN is undefined, tie err_cnt to 8'h00 and implement no counter logic; err behaviour is identical in both builds.

Verification
REQ-036 SHALL cover: pop 0x6001A55A then 0x9FFF0000 -> key_status=0x9FFF0000, one key_status_valid pulse, no mem_wr, state back to HDR.
REQ-037 SHALL cover: pop 0x2002A55A, 0x0123ABCD, 0x89ABCDEF -> trans_type=1; writes (addr 0, 0x0123ABCD), then (addr 4, 0x89ABCDEF); then HDR.
REQ-038 SHALL cover: CODE packet with mem_wr_ready low for 5 cycles -> mem_wr, mem_addr and mem_wr_data stable for those 5 cycles, usb_rd low, no pop.
REQ-039 SHALL cover: pop 0x20020000 -> err=1 (err_cnt=1 with the macro defined), state stays HDR; a following 0x6001A55A packet is parsed normally.
REQ-040 SHALL cover: pop 0x0003A55A then 3 words -> all 3 popped, no mem_wr, no key_status_valid; then HDR.
REQ-041 SHALL cover: rst pulsed after the first payload word of 0xC004A55A -> all outputs 0, and the next word popped is decoded as a header.
